// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter between pipeline writeback and long-latency results
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [37:0] pipe_wb_back,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  input  logic [4:0]  chk_rs,
  input  logic [4:0]  chk_rt,
  output logic        pend_hit_rs,
  output logic        pend_hit_rt,
  output logic        pend_busy,
  output logic        stall_req,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic        pipe_we;
  logic [31:0] pipe_wd;
  logic [4:0]  pipe_rw;
  logic        pipe_occ;
  logic        fifo_empty;
  logic        fifo_full;
  logic        do_pop;
  logic        do_push;

  assign pipe_we = pipe_wb_back[37];
  assign pipe_wd = pipe_wb_back[36:5];
  assign pipe_rw = pipe_wb_back[4:0];

  // Outputs are forced quiet while reset is held, even though reset itself is asynchronous.
  assign pipe_occ   = rst && pipe_we && (pipe_rw != 5'd0);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(DEPTH));

  assign mdu_ready = rst && !fifo_full;
  assign pend_busy = !fifo_empty;
  assign stall_req = (starve_cnt == SW'(STARVE_LIMIT));

  assign do_pop  = rst && !pipe_occ && !fifo_empty;
  assign do_push = mdu_valid && mdu_ready && (mdu_rd != 5'd0);

  always_comb begin
    rf_we = 1'b0;
    rf_wa = 5'd0;
    rf_wd = 32'd0;
    if (pipe_occ) begin
      rf_we = 1'b1;
      rf_wa = pipe_rw;
      rf_wd = pipe_wd;
    end else if (do_pop) begin
      rf_we = 1'b1;
      rf_wa = rd_mem[rd_ptr];
      rf_wd = data_mem[rd_ptr];
    end
  end

  // An entry is live when its distance from the head is below the occupancy count.
  always_comb begin
    logic [AW-1:0] offs;
    pend_hit_rs = 1'b0;
    pend_hit_rt = 1'b0;
    offs        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = AW'(i) - rd_ptr;
      if (CW'(offs) < count) begin
        if ((chk_rs != 5'd0) && (rd_mem[i] == chk_rs)) pend_hit_rs = 1'b1;
        if ((chk_rt != 5'd0) && (rd_mem[i] == chk_rt)) pend_hit_rt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_mem[wr_ptr]   <= mdu_rd;
      data_mem[wr_ptr] <= mdu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (fifo_empty || do_pop) begin
      starve_cnt <= '0;
    end else if (!stall_req) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter against a queue-based reference model
module tb_wb_port_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [37:0] pipe_wb_back = '0;
  logic        mdu_valid = 1'b0;
  logic        mdu_ready;
  logic [4:0]  mdu_rd = '0;
  logic [31:0] mdu_data = '0;
  logic [4:0]  chk_rs = '0;
  logic [4:0]  chk_rt = '0;
  logic        pend_hit_rs, pend_hit_rt, pend_busy, stall_req;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst), .pipe_wb_back(pipe_wb_back),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .chk_rs(chk_rs), .chk_rt(chk_rt), .pend_hit_rs(pend_hit_rs), .pend_hit_rt(pend_hit_rt),
    .pend_busy(pend_busy), .stall_req(stall_req), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ready;
    logic        busy;
    logic        hit_rs;
    logic        hit_rt;
    logic        stall;
  } exp_t;

  ent_t fifo[$];
  exp_t exp_q[$];
  int   starve = 0, starve_nxt = 0;
  bit   pend_pop = 0, pend_push = 0;
  ent_t push_e;
  int   vectors = 0, errors = 0;

  // Applies the previous cycle's model transition, drives a new input set, predicts the outputs.
  task automatic drive(input bit r, input bit pwe, input logic [4:0] prw, input logic [31:0] pwd,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic [4:0] crs, input logic [4:0] crt);
    exp_t e;
    ent_t tmp;
    bit   occ;
    @(posedge clk);
    #1;
    if (pend_pop) tmp = fifo.pop_front();
    if (pend_push) fifo.push_back(push_e);
    starve = starve_nxt;
    rst = r;
    pipe_wb_back = {pwe, pwd, prw};
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    chk_rs = crs; chk_rt = crt;
    if (!r) begin
      fifo.delete();
      starve = 0;
    end
    occ = r && pwe && (prw != 0);
    e.we = 0; e.wa = 0; e.wd = 0;
    if (occ) begin
      e.we = 1; e.wa = prw; e.wd = pwd;
    end else if (r && fifo.size() > 0) begin
      e.we = 1; e.wa = fifo[0].rd; e.wd = fifo[0].d;
    end
    e.ready  = r && (fifo.size() < DEPTH);
    e.busy   = fifo.size() != 0;
    e.hit_rs = 0; e.hit_rt = 0;
    foreach (fifo[i]) begin
      if (crs != 0 && fifo[i].rd == crs) e.hit_rs = 1;
      if (crt != 0 && fifo[i].rd == crt) e.hit_rt = 1;
    end
    e.stall   = (starve == STARVE_LIMIT);
    pend_pop  = r && !occ && fifo.size() > 0;
    pend_push = r && mv && e.ready && (mrd != 0);
    push_e.rd = mrd; push_e.d = md;
    if (!r || fifo.size() == 0 || pend_pop) starve_nxt = 0;
    else starve_nxt = (starve < STARVE_LIMIT) ? starve + 1 : starve;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [4:0] crs = 0, input logic [4:0] crt = 0);
    drive(1, 0, 0, 0, 0, 0, 0, crs, crt);
  endtask

  task automatic busy_pipe(input bit mv = 0, input logic [4:0] mrd = 0, input logic [31:0] md = 0,
                           input logic [4:0] crs = 0, input logic [4:0] crt = 0);
    drive(1, 1, 5'd7, 32'hAA55AA55, mv, mrd, md, crs, crt);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (rf_we !== e.we) begin errors++; $display("FAIL rf_we t=%0t got %b exp %b", $time, rf_we, e.we); end
        if (rf_wa !== e.wa) begin errors++; $display("FAIL rf_wa t=%0t got %0d exp %0d", $time, rf_wa, e.wa); end
        if (rf_wd !== e.wd) begin errors++; $display("FAIL rf_wd t=%0t got %h exp %h", $time, rf_wd, e.wd); end
        if (mdu_ready !== e.ready) begin errors++; $display("FAIL mdu_ready t=%0t got %b exp %b", $time, mdu_ready, e.ready); end
        if (pend_busy !== e.busy) begin errors++; $display("FAIL pend_busy t=%0t got %b exp %b", $time, pend_busy, e.busy); end
        if (pend_hit_rs !== e.hit_rs) begin errors++; $display("FAIL pend_hit_rs t=%0t got %b exp %b", $time, pend_hit_rs, e.hit_rs); end
        if (pend_hit_rt !== e.hit_rt) begin errors++; $display("FAIL pend_hit_rt t=%0t got %b exp %b", $time, pend_hit_rt, e.hit_rt); end
        if (stall_req !== e.stall) begin errors++; $display("FAIL stall_req t=%0t got %b exp %b", $time, stall_req, e.stall); end
      end
    end
  end

  initial begin : stimulus
    int budget;
    int pbusy;
    repeat (2) drive(0, 1, 5'd4, 32'h1234, 1, 5'd3, 32'h55, 5'd3, 5'd4);

    // Idle drain
    drive(1, 0, 0, 0, 1, 5'd3, 32'hDEADBEEF, 5'd3, 0);
    idle(5'd3);
    idle(5'd3);

    // Pipe priority, then rw=0 acting as a free slot
    busy_pipe(1, 5'd5, 32'h11, 5'd5);
    busy_pipe(0, 0, 0, 5'd5);
    idle(5'd5);
    busy_pipe(1, 5'd6, 32'h22);
    drive(1, 1, 5'd0, 32'hFFFF0000, 0, 0, 0, 5'd6, 0);
    idle();

    // Full, drain one, zero-destination handshake
    busy_pipe(1, 5'd1, 32'hA1);
    busy_pipe(1, 5'd2, 32'hA2);
    busy_pipe(1, 5'd8, 32'hA8);
    drive(1, 0, 0, 0, 1, 5'd8, 32'hA8, 5'd1, 5'd2);
    busy_pipe(0, 0, 0, 5'd1, 5'd2);
    idle(); idle();
    drive(1, 0, 0, 0, 1, 5'd0, 32'h99, 0, 0);
    idle(); idle();

    // Starvation
    busy_pipe(1, 5'd10, 32'hC0FFEE);
    repeat (6) busy_pipe();
    idle();
    idle();

    // Hazard lookup
    busy_pipe(1, 5'd9, 32'h9);
    busy_pipe(1, 5'd12, 32'hC);
    busy_pipe(0, 0, 0, 5'd12, 5'd0);
    repeat (3) idle(5'd12, 5'd9);

    // Reset mid-operation
    busy_pipe(1, 5'd13, 32'hD);
    busy_pipe(1, 5'd14, 32'hE);
    busy_pipe(0, 0, 0, 5'd13, 5'd14);
    drive(0, 1, 5'd15, 32'hF, 1, 5'd16, 32'h16, 5'd13, 5'd14);
    repeat (3) idle(5'd13, 5'd14);

    // Randomized traffic with varying pipe load
    for (int blk = 0; blk < 20; blk++) begin
      pbusy = $urandom_range(0, 100);
      for (int c = 0; c < 100; c++) begin
        drive(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 99) < pbusy), 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 1), 5'($urandom_range(0, 15)), $urandom,
              5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      end
    end
    repeat (4) idle();

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout pending %0d exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
